denorm_shift: RTL

- Multi-cycle right-shift denormaliser for FP mantissas. It is the opposite direction of the leading-zero counter path: clz measures how far to shift left, and this block shifts right by a given exponent difference.
- Collects guard, round and sticky bits for the rounder.
- Used for operand alignment in add/sub and for subnormal results.
- One log-stage per cycle. Valid/ready handshake on both sides.

---
 rtl/denorm_shift.sv | 107 ++++++++++
 1 files changed

// File: rtl/denorm_shift.sv
// Right-shift denormaliser: {man,guard,round} shifted by a clamped amount, one log-stage per cycle, sticky collected.
// Latency num_stages cycles from accept; result held in DONE until out_ready, no new accept until drained.
module denorm_shift #(
  parameter int man_width = 24,
  parameter int exp_width = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [man_width-1:0]   in_man,
  input  logic [exp_width+1:0]   in_shamt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [man_width-1:0]   out_man,
  output logic                   out_guard,
  output logic                   out_round,
  output logic                   out_sticky,
  output logic                   out_sat
);

  localparam int w_width    = man_width + 2;
  localparam int num_stages = $clog2(man_width + 3);
  localparam int cnt_width  = (num_stages > 1) ? $clog2(num_stages) : 1;
  localparam int sh_width   = exp_width + 2;
  localparam logic [sh_width-1:0]  sh_max     = sh_width'(w_width);
  localparam logic [cnt_width-1:0] last_stage = cnt_width'(num_stages - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [w_width-1:0]      w_q;
  logic                    sticky_q;
  logic                    sat_q;
  logic [num_stages-1:0]   shamt_q;
  logic [cnt_width-1:0]    stage_q;

  logic                    in_sat;
  logic [num_stages-1:0]   in_shamt_c;
  logic [w_width-1:0]      w_shifted;
  logic                    w_lost;

  // Clamping at w_width shifts everything into sticky, which is all a larger amount could do.
  assign in_sat     = (in_shamt >= sh_max);
  assign in_shamt_c = in_sat ? sh_max[num_stages-1:0] : in_shamt[num_stages-1:0];

  always_comb begin
    w_shifted = w_q >> (1 << stage_q);
    w_lost    = 1'b0;
    for (int i = 0; i < w_width; i++) begin
      if (i < (1 << stage_q)) w_lost = w_lost | w_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SHIFT;
      SHIFT:   if (stage_q == last_stage) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      w_q      <= '0;
      sticky_q <= 1'b0;
      sat_q    <= 1'b0;
      shamt_q  <= '0;
      stage_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            w_q      <= {in_man, 2'b00};
            sticky_q <= 1'b0;
            sat_q    <= in_sat;
            shamt_q  <= in_shamt_c;
            stage_q  <= '0;
          end
        end
        SHIFT: begin
          // Every stage takes a cycle whether or not it shifts, so latency is fixed.
          if (shamt_q[stage_q]) begin
            w_q      <= w_shifted;
            sticky_q <= sticky_q | w_lost;
          end
          stage_q <= stage_q + cnt_width'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_man    = w_q[w_width-1:2];
  assign out_guard  = w_q[1];
  assign out_round  = w_q[0];
  assign out_sticky = sticky_q;
  assign out_sat    = sat_q;

endmodule
